// File: rtl/layer_priority_arbiter.sv
// rtl/layer_priority_arbiter.sv - per-pixel layer priority arbiter with frame-synchronous rank table and collision report
//
// Ports:
//   clk, resetN              pixel clock, asynchronous active-low reset
//   startOfFrame             one-cycle pulse at the first pixel of a frame
//   drawReq, layerRGB        per-layer request and RGB332 (layer i at [8i+7:8i])
//   backGroundRGB            RGB332 shown when no layer requests
//   cfgWrEn/cfgLayer/cfgRank write one pending rank-table entry (rank 0 = highest)
//   pixelRGB, winnerValid,   registered arbitration result (1 clk latency)
//   winnerIdx
//   collReport/collValid/    per-frame overlap report with valid/ack handshake
//   collAck, collOverrun     and sticky overwrite flag
module layer_priority_arbiter #(
    parameter int N_LAYERS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [N_LAYERS-1:0]   drawReq,
    input  logic [N_LAYERS*8-1:0] layerRGB,
    input  logic [7:0]            backGroundRGB,
    input  logic                  cfgWrEn,
    input  logic [IDX_W-1:0]      cfgLayer,
    input  logic [IDX_W-1:0]      cfgRank,
    output logic [7:0]            pixelRGB,
    output logic                  winnerValid,
    output logic [IDX_W-1:0]      winnerIdx,
    output logic [N_LAYERS-1:0]   collReport,
    output logic                  collValid,
    input  logic                  collAck,
    output logic                  collOverrun
);

    localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(N_LAYERS);

    typedef enum logic {ST_IDLE, ST_REPORT} state_t;

    logic [IDX_W-1:0]    r_pending [N_LAYERS];
    logic [IDX_W-1:0]    r_active  [N_LAYERS];
    logic [N_LAYERS-1:0] r_acc;
    state_t              r_state;

    state_t              w_state_nxt;
    logic [N_LAYERS-1:0] w_report_nxt;
    logic                w_overrun_nxt;
    logic                w_found;
    logic [IDX_W-1:0]    w_best_rank;
    logic [IDX_W-1:0]    w_best_idx;
    logic [7:0]          w_best_rgb;
    logic                w_overlap;
    logic [N_LAYERS-1:0] w_overlap_bits;
    logic                w_cfg_ok;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_overlap      = |(drawReq & (drawReq - 1'b1));
    assign w_overlap_bits = w_overlap ? drawReq : '0;
    assign w_cfg_ok       = cfgWrEn && ({1'b0, cfgLayer} < LP_N);

    // Strict less-than while scanning upward makes the lower index win rank ties.
    always_comb begin
        w_found     = 1'b0;
        w_best_rank = '0;
        w_best_idx  = '0;
        w_best_rgb  = backGroundRGB;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (drawReq[i] && (!w_found || (r_active[i] < w_best_rank))) begin
                w_found     = 1'b1;
                w_best_rank = r_active[i];
                w_best_idx  = IDX_W'(i);
                w_best_rgb  = layerRGB[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixelRGB    <= '0;
            winnerValid <= 1'b0;
            winnerIdx   <= '0;
        end else begin
            pixelRGB    <= w_best_rgb;
            winnerValid <= w_found;
            winnerIdx   <= w_best_idx;
        end
    end

    // Active copies pending as it stood before any same-cycle write, so a write
    // coincident with startOfFrame waits for the following frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                r_pending[i] <= IDX_W'(i);
                r_active[i]  <= IDX_W'(i);
            end
        end else begin
            if (startOfFrame) begin
                for (int i = 0; i < N_LAYERS; i++) begin
                    r_active[i] <= r_pending[i];
                end
            end
            if (w_cfg_ok) begin
                r_pending[cfgLayer] <= cfgRank;
            end
        end
    end

    // The startOfFrame cycle's own overlap belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc <= '0;
        end else if (startOfFrame) begin
            r_acc <= w_overlap_bits;
        end else begin
            r_acc <= r_acc | w_overlap_bits;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_report_nxt  = collReport;
        w_overrun_nxt = collOverrun;
        case (r_state)
            ST_IDLE: begin
                if (startOfFrame) begin
                    w_report_nxt = r_acc;
                    w_state_nxt  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (startOfFrame) begin
                    w_report_nxt  = r_acc;
                    w_overrun_nxt = !collAck;
                end else if (collAck) begin
                    w_state_nxt   = ST_IDLE;
                    w_overrun_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            collReport  <= '0;
            collOverrun <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            collReport  <= w_report_nxt;
            collOverrun <= w_overrun_nxt;
        end
    end

    assign collValid = (r_state == ST_REPORT);

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// tb/tb_layer_priority_arbiter.sv - directed self-checking bench for layer_priority_arbiter
module tb_layer_priority_arbiter;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  drawReq;
    logic [31:0] layerRGB;
    logic [7:0]  backGroundRGB;
    logic        cfgWrEn;
    logic [1:0]  cfgLayer;
    logic [1:0]  cfgRank;
    logic [7:0]  pixelRGB;
    logic        winnerValid;
    logic [1:0]  winnerIdx;
    logic [3:0]  collReport;
    logic        collValid;
    logic        collAck;
    logic        collOverrun;

    int n_cmp;
    int n_err;

    layer_priority_arbiter #(.N_LAYERS(4), .IDX_W(2)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .drawReq       (drawReq),
        .layerRGB      (layerRGB),
        .backGroundRGB (backGroundRGB),
        .cfgWrEn       (cfgWrEn),
        .cfgLayer      (cfgLayer),
        .cfgRank       (cfgRank),
        .pixelRGB      (pixelRGB),
        .winnerValid   (winnerValid),
        .winnerIdx     (winnerIdx),
        .collReport    (collReport),
        .collValid     (collValid),
        .collAck       (collAck),
        .collOverrun   (collOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, clock them in, sample at the next falling edge.
    task automatic cyc(input logic sof, input logic [3:0] req, input logic wr,
                       input logic [1:0] wl, input logic [1:0] wrk, input logic ack);
        startOfFrame = sof;
        drawReq      = req;
        cfgWrEn      = wr;
        cfgLayer     = wl;
        cfgRank      = wrk;
        collAck      = ack;
        @(posedge clk);
        @(negedge clk);
        startOfFrame = 1'b0;
        drawReq      = '0;
        cfgWrEn      = 1'b0;
        collAck      = 1'b0;
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] rgb, input logic v, input logic [1:0] idx);
        chk({tag, ".rgb"}, {24'd0, pixelRGB}, {24'd0, rgb});
        chk({tag, ".wv"},  {31'd0, winnerValid}, {31'd0, v});
        chk({tag, ".idx"}, {30'd0, winnerIdx}, {30'd0, idx});
    endtask

    task automatic chk_col(input string tag, input logic [3:0] rep, input logic v, input logic ovr);
        chk({tag, ".rep"}, {28'd0, collReport}, {28'd0, rep});
        chk({tag, ".cv"},  {31'd0, collValid}, {31'd0, v});
        chk({tag, ".ovr"}, {31'd0, collOverrun}, {31'd0, ovr});
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        drawReq       = '0;
        layerRGB      = {8'h3F, 8'h1C, 8'hE0, 8'h11};
        backGroundRGB = 8'h03;
        cfgWrEn       = 1'b0;
        cfgLayer      = '0;
        cfgRank       = '0;
        collAck       = 1'b0;
        #1;
        chk_pix("reset", 8'h00, 1'b0, 2'd0);
        chk_col("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;

        // First frame after reset reports an all-zero frame.
        cyc(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("first_sof", 4'b0000, 1'b1, 1'b0);
        chk_pix("first_sof_bg", 8'h03, 1'b0, 2'd0);
        cyc(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
        chk_col("first_ack", 4'b0000, 1'b0, 1'b0);

        // Identity ranks: layer1 beats layer2. acc = 0110.
        cyc(1'b0, 4'b0110, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("identity", 8'hE0, 1'b1, 2'd1);
        cyc(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("background", 8'h03, 1'b0, 2'd0);

        // Mid-frame write of layer2 rank 0 stays pending.
        cyc(1'b0, 4'b0110, 1'b1, 2'd2, 2'd0, 1'b0);
        chk_pix("wr_cycle", 8'hE0, 1'b1, 2'd1);
        cyc(1'b0, 4'b0110, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("wr_pending", 8'hE0, 1'b1, 2'd1);

        // Frame start: old table in this cycle; coincident write layer3 rank 0 stays pending.
        cyc(1'b1, 4'b0110, 1'b1, 2'd3, 2'd0, 1'b0);
        chk_pix("sof_old_table", 8'hE0, 1'b1, 2'd1);
        chk_col("report_0110", 4'b0110, 1'b1, 1'b0);
        cyc(1'b0, 4'b0110, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("new_table", 8'h1C, 1'b1, 2'd2);

        // Layer3 still rank 3 this frame; ack here. acc = 0110|1100.
        cyc(1'b0, 4'b1100, 1'b0, 2'd0, 2'd0, 1'b1);
        chk_pix("coinc_wr_deferred", 8'h1C, 1'b1, 2'd2);
        chk_col("ack", 4'b0110, 1'b0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
        chk_col("ack_idle_ignored", 4'b0110, 1'b0, 1'b0);
        cyc(1'b0, 4'b1001, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("l0_over_l3", 8'h11, 1'b1, 2'd0);

        cyc(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("report_1111", 4'b1111, 1'b1, 1'b0);

        // Layer0 and layer3 both rank 0: lower index wins.
        cyc(1'b0, 4'b1001, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("tie", 8'h11, 1'b1, 2'd0);
        cyc(1'b0, 4'b1000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("l3_alone", 8'h3F, 1'b1, 2'd3);

        // No ack across a frame start: overrun.
        cyc(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("overrun", 4'b1001, 1'b1, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b1);
        chk_col("ack_clears", 4'b1001, 1'b0, 1'b0);

        // Frame with no overlap reports zero.
        cyc(1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("no_overlap", 4'b0000, 1'b1, 1'b0);
        // Overlap in the next frame's start cycle, acked at that same start.
        cyc(1'b0, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        cyc(1'b1, 4'b0101, 1'b0, 2'd0, 2'd0, 1'b1);
        chk_col("ack_with_sof", 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("sof_cycle_counts", 4'b0101, 1'b1, 1'b1);

        // Asynchronous reset mid-frame.
        drawReq = 4'b0110;
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        chk_pix("mid_reset", 8'h00, 1'b0, 2'd0);
        chk_col("mid_reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        drawReq = '0;
        resetN  = 1'b1;
        cyc(1'b0, 4'b0110, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_pix("post_reset_ranks", 8'hE0, 1'b1, 2'd1);
        cyc(1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0);
        chk_col("post_reset_report", 4'b0110, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/layer_priority_arbiter.md
Name: layer_priority_arbiter

Overview:
- Per-pixel arbiter that shares the single 8-bit RGB output path between N sprite layers (tank, brick, bullets, ...) and the background.
- Priorities come from a runtime-programmable rank table. Updates are double-buffered and take effect only at frame start.
- Accumulates per-frame layer-overlap (collision) flags and hands them to game logic through a valid/ack handshake.
- Sits between the object drawers and the RGB expansion stage that drives the VGA DAC.

Parameters:
- N_LAYERS, 4, number of requesting layers (2..8).
- IDX_W, 2, width of layer index / rank field; must satisfy 2**IDX_W >= N_LAYERS.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame.
- drawReq  in  N_LAYERS  per-layer drawing request for current pixel.
- layerRGB  in  N_LAYERS*8  per-layer RGB332; layer i occupies bits [8i+7:8i].
- backGroundRGB  in  8  background RGB332.
- cfgWrEn  in  1  write one rank-table entry.
- cfgLayer  in  IDX_W  layer index being written.
- cfgRank  in  IDX_W  new rank; 0 = highest priority.
- pixelRGB  out  8  arbitrated RGB332.
- winnerValid  out  1  1 when a layer (not background) won the pixel.
- winnerIdx  out  IDX_W  index of the winning layer; 0 when winnerValid=0.
- collReport  out  N_LAYERS  bit i = layer i overlapped another layer during the reported frame.
- collValid  out  1  collReport holds an unconsumed report.
- collAck  in  1  consumer acknowledges the report.
- collOverrun  out  1  sticky: a report was overwritten before being acked.

Behaviour:
- Reset: active and pending rank tables = identity (layer i rank i). pixelRGB=0, winnerValid=0, winnerIdx=0, collReport=0, collValid=0, collOverrun=0, collision accumulator=0.
- Arbitration is combinational over the active table; outputs are registered, so latency is exactly 1 clk (inputs at cycle t appear at t+1).
- Winner = requesting layer with numerically lowest rank. Equal ranks: lower layer index wins.
- No drawReq set: pixelRGB=backGroundRGB, winnerValid=0, winnerIdx=0.
- Config writes:
  - cfgWrEn updates pending[cfgLayer]; the active table is unchanged.
  - cfgLayer >= N_LAYERS: write ignored.
  - On startOfFrame, active <= pending, using pending as it was before any same-cycle write.
  - A write coincident with startOfFrame lands in pending and applies at the next frame.
  - Arbitration in the startOfFrame cycle uses the old active table.
- Collision accumulator:
  - Each cycle with popcount(drawReq) >= 2, OR the set drawReq bits into the accumulator.
  - On startOfFrame the accumulator clears, then takes that cycle's overlap term, so that cycle belongs to the new frame.
- Report FSM, two states:
  - IDLE (collValid=0): on startOfFrame, collReport <= accumulator (previous frame, even if zero), collValid <= 1, go to REPORT.
  - REPORT (collValid=1):
    - collAck without startOfFrame: collValid <= 0, go to IDLE. collReport holds its value.
    - startOfFrame with collAck: load new report, stay in REPORT, no overrun.
    - startOfFrame without collAck: load new report, collOverrun <= 1.
  - collOverrun clears on the next collAck.
  - collAck in IDLE is ignored.
- Reset mid-frame: all state returns to reset values immediately. The first startOfFrame after reset reports an all-zero frame if no overlap has occurred.

Test Plan:
- Reset identity, N=4: drawReq=4'b0110, layer1=8'hE0, layer2=8'h1C -> next cycle pixelRGB=8'hE0, winnerValid=1, winnerIdx=1.
- Background path: drawReq=0, backGroundRGB=8'h03 -> pixelRGB=8'h03, winnerValid=0, winnerIdx=0.
- Deferred config:
  - Write layer2 rank 0 mid-frame -> layer1 still wins until startOfFrame; from the cycle after that pulse, layer2 (8'h1C) wins.
  - A write issued in the startOfFrame cycle itself takes effect only one frame later.
- Rank tie: set layer3 rank 0 and layer0 rank 0, drawReq=4'b1001 -> winnerIdx=0.
- Collision report:
  - drawReq=4'b0011 for one cycle mid-frame, then startOfFrame -> collReport=4'b0011, collValid=1.
  - collAck -> collValid=0.
  - Next frame with no overlap -> collReport=4'b0000.
- Overrun: leave collValid=1 across a startOfFrame without ack -> report replaced, collOverrun=1. collAck clears both collOverrun and collValid. Ack coincident with startOfFrame -> collValid stays 1, collOverrun=0.
